// File: rtl/conv_mac_scheduler_if.sv
// Handshake and operand/result bus for the time-multiplexed nibble convolution sequencer.
// The requester drives start/abort and operands; the sequencer returns busy/done and the packed result.
interface conv_mac_scheduler_if #(
    parameter int DW      = 4,
    parameter int X_LEN   = 8,
    parameter int H_LEN   = 8,
    parameter int OUT_LEN = X_LEN + H_LEN
);
    logic                     start;
    logic                     abort;
    logic [X_LEN*DW-1:0]      x_in;
    logic [H_LEN*DW-1:0]      h_in;
    logic                     busy;
    logic                     done;
    logic [OUT_LEN*DW-1:0]    y_out;

    modport master (
        output start, abort, x_in, h_in,
        input  busy, done, y_out
    );

    modport slave (
        input  start, abort, x_in, h_in,
        output busy, done, y_out
    );
endinterface

// File: rtl/conv_mac_scheduler.sv
// Sequences one shared multiply-accumulate over every (output index, tap) pair of the nibble
// convolution, publishing the packed result with a start/busy/done handshake.
module conv_mac_scheduler #(
    parameter  int DW      = 4,
    parameter  int X_LEN   = 8,
    parameter  int H_LEN   = 8,
    localparam int OUT_LEN = X_LEN + H_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_mac_scheduler_if.slave  bus
);
    localparam int IW = $clog2(OUT_LEN);
    localparam int JW = $clog2(H_LEN);
    localparam int XW = $clog2(X_LEN);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Unsigned product truncated to the element width; higher bits never reach y.
    function automatic logic [DW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return p[DW-1:0];
    endfunction

    state_t                 r_state;
    logic [DW-1:0]          r_x      [X_LEN];
    logic [DW-1:0]          r_h      [H_LEN];
    logic [DW-1:0]          r_shadow [OUT_LEN];
    logic [IW-1:0]          r_i;
    logic [JW-1:0]          r_j;
    logic [DW-1:0]          r_acc;
    logic                   r_busy;
    logic                   r_done;
    logic [OUT_LEN*DW-1:0]  r_y;

    logic [IW-1:0]          w_j_ext;
    logic [IW-1:0]          w_diff;
    logic                   w_valid;
    logic [DW-1:0]          w_term;
    logic [DW-1:0]          w_sum;
    logic                   w_last_tap;
    logic                   w_last_pair;
    logic [OUT_LEN*DW-1:0]  w_y_next;

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.y_out = r_y;

    // Current pair's contribution; out-of-range x indices contribute zero but still take the cycle.
    always_comb begin
        w_j_ext     = IW'(r_j);
        w_diff      = r_i - w_j_ext;
        w_valid     = (r_i >= w_j_ext) && (w_diff <= IW'(X_LEN - 1));
        if (w_valid) begin
            w_term = mac_term(r_x[w_diff[XW-1:0]], r_h[r_j]);
        end else begin
            w_term = {DW{1'b0}};
        end
        w_sum       = r_acc + w_term;
        w_last_tap  = (r_j == JW'(H_LEN - 1));
        w_last_pair = w_last_tap && (r_i == IW'(OUT_LEN - 1));
    end

    // Shadow result with the element finishing this cycle merged in, so the final y lands with done.
    always_comb begin
        w_y_next = {(OUT_LEN*DW){1'b0}};
        for (int k = 0; k < OUT_LEN; k++) begin
            if (IW'(k) == r_i) begin
                w_y_next[k*DW +: DW] = w_sum;
            end else begin
                w_y_next[k*DW +: DW] = r_shadow[k];
            end
        end
    end

    // Sequencer FSM: capture on start, one MAC per edge in RUN, publish result on the last pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= {IW{1'b0}};
            r_j     <= {JW{1'b0}};
            r_acc   <= {DW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= {(OUT_LEN*DW){1'b0}};
            for (int k = 0; k < X_LEN; k++)   r_x[k]      <= {DW{1'b0}};
            for (int k = 0; k < H_LEN; k++)   r_h[k]      <= {DW{1'b0}};
            for (int k = 0; k < OUT_LEN; k++) r_shadow[k] <= {DW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        for (int k = 0; k < X_LEN; k++) r_x[k] <= bus.x_in[k*DW +: DW];
                        for (int k = 0; k < H_LEN; k++) r_h[k] <= bus.h_in[k*DW +: DW];
                        r_i     <= {IW{1'b0}};
                        r_j     <= {JW{1'b0}};
                        r_acc   <= {DW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_last_tap) begin
                        r_shadow[r_i] <= w_sum;
                        r_acc         <= {DW{1'b0}};
                        r_j           <= {JW{1'b0}};
                        r_i           <= r_i + IW'(1);
                        if (w_last_pair) begin
                            r_y     <= w_y_next;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_acc   <= w_sum;
                        r_j     <= r_j + JW'(1);
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
